// File: rtl/lcd_pkg.sv
// Shared types, command constants and helpers for the character-LCD sequencer.
package lcd_pkg;

   localparam int CNT_W        = 20;
   localparam int INIT_ROM_LEN = 5;

   localparam logic [7:0] LCD_CMD_FUNCSET = 8'h38;
   localparam logic [7:0] LCD_CMD_DISPON  = 8'h0E;
   localparam logic [7:0] LCD_CMD_ENTRY   = 8'h06;
   localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;
   localparam logic [7:0] LCD_CMD_HOME    = 8'h02;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [2:0] {
      ST_PWR_WAIT,
      ST_INIT_LOAD,
      ST_INIT_WAIT,
      ST_IDLE,
      ST_XFER,
      ST_DONE
   } lcd_state_e;

   typedef enum logic [1:0] {
      PH_IDLE,
      PH_SETUP,
      PH_EN_HIGH,
      PH_EXEC_WAIT
   } lcd_phase_e;

   // Terminal count for a duration of cyc clocks; zero is stretched to one clock.
   function automatic logic [CNT_W-1:0] last_cnt(input int unsigned cyc);
      if (cyc <= 1) return '0;
      return CNT_W'(cyc - 1);
   endfunction

   function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
      return !rs && (b == LCD_CMD_CLEAR || b == LCD_CMD_HOME || b == 8'h03);
   endfunction

   function automatic logic [7:0] init_rom(input logic [2:0] idx);
      logic [7:0] b;
      case (idx)
         3'd0, 3'd1: b = LCD_CMD_FUNCSET;
         3'd2:       b = LCD_CMD_DISPON;
         3'd3:       b = LCD_CMD_ENTRY;
         default:    b = LCD_CMD_CLEAR;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/lcd_bus_timer.sv
// Strobe engine for one LCD write: RS/data setup, enable pulse, then execution wait.
// fin pulses in the last clk_en-qualified cycle of the execution wait.
module lcd_bus_timer
   import lcd_pkg::*;
#(
   parameter int unsigned SETUP_CYC     = 2,
   parameter int unsigned EN_HIGH_CYC   = 12,
   parameter int unsigned EXEC_CYC      = 2000,
   parameter int unsigned LONG_EXEC_CYC = 82000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clk_en,
   input  logic       go,
   input  logic [7:0] go_byte,
   input  logic       go_rs,
   input  logic       go_long,
   output logic       fin,
   output logic       lcd_enable,
   output logic       lcd_rs,
   output logic [7:0] lcd_data
);

   localparam logic [CNT_W-1:0] SETUP_LAST = last_cnt(SETUP_CYC);
   localparam logic [CNT_W-1:0] EN_LAST    = last_cnt(EN_HIGH_CYC);
   localparam logic [CNT_W-1:0] EXEC_LAST  = last_cnt(EXEC_CYC);
   localparam logic [CNT_W-1:0] LONG_LAST  = last_cnt(LONG_EXEC_CYC);

   lcd_phase_e       phase_q, phase_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             en_q, en_d;
   logic             rs_q, rs_d;
   logic [7:0]       data_q, data_d;
   logic             long_q, long_d;
   logic [CNT_W-1:0] exec_last;

   assign exec_last = long_q ? LONG_LAST : EXEC_LAST;

   always_comb begin
      // NOTE: every _d starts from its _q so no path through this block can infer a latch.
      phase_d = phase_q;
      cnt_d   = cnt_q;
      en_d    = en_q;
      rs_d    = rs_q;
      data_d  = data_q;
      long_d  = long_q;
      fin     = 1'b0;
      if (clk_en) begin
         case (phase_q)
            PH_IDLE: begin
               if (go) begin
                  phase_d = PH_SETUP;
                  cnt_d   = '0;
                  rs_d    = go_rs;
                  data_d  = go_byte;
                  long_d  = go_long;
               end
            end
            PH_SETUP: begin
               if (cnt_q == SETUP_LAST) begin
                  phase_d = PH_EN_HIGH;
                  cnt_d   = '0;
                  en_d    = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            PH_EN_HIGH: begin
               if (cnt_q == EN_LAST) begin
                  phase_d = PH_EXEC_WAIT;
                  cnt_d   = '0;
                  en_d    = 1'b0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            PH_EXEC_WAIT: begin
               if (cnt_q == exec_last) begin
                  phase_d = PH_IDLE;
                  cnt_d   = '0;
                  fin     = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: phase_d = PH_IDLE;
         endcase
      end
   end

   // RS/data are never cleared after a write: they hold until the next SETUP.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: sequential state is updated only with non-blocking assignments.
         phase_q <= PH_IDLE;
         cnt_q   <= '0;
         en_q    <= 1'b0;
         rs_q    <= 1'b0;
         data_q  <= 8'h00;
         long_q  <= 1'b0;
      end else begin
         phase_q <= phase_d;
         cnt_q   <= cnt_d;
         en_q    <= en_d;
         rs_q    <= rs_d;
         data_q  <= data_d;
         long_q  <= long_d;
      end
   end

   assign lcd_enable = en_q;
   assign lcd_rs     = rs_q;
   assign lcd_data   = data_q;

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// Custom-instruction front end for an 8-bit write-only HD44780 bus: init ROM, pending request, done/result.
// Define LCD_INIT_SEQ_EN to build in the power-up wait and init ROM; otherwise reset lands in IDLE with init_ok=1.
module lcd_cmd_sequencer
   import lcd_pkg::*;
#(
   parameter int unsigned SETUP_CYC     = 2,
   parameter int unsigned EN_HIGH_CYC   = 12,
   parameter int unsigned EXEC_CYC      = 2000,
   parameter int unsigned LONG_EXEC_CYC = 82000,
   parameter int unsigned PWRUP_CYC     = 750000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk_en,
   input  logic        start,
   input  logic [31:0] dataa,
   input  logic [31:0] datab,
   output logic [31:0] result,
   output logic        done,
   output logic        lcd_enable,
   output logic        lcd_rs,
   output logic        lcd_rw,
   output logic [7:0]  lcd_data
);

`ifdef LCD_INIT_SEQ_EN
   localparam lcd_state_e       RST_STATE  = ST_PWR_WAIT;
   localparam logic             RST_INITOK = 1'b0;
   localparam logic [CNT_W-1:0] PWRUP_LAST = last_cnt(PWRUP_CYC);
   localparam logic [2:0]       ROM_LAST   = 3'(INIT_ROM_LEN - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       rom_idx_q, rom_idx_d;
`else
   localparam lcd_state_e RST_STATE  = ST_IDLE;
   localparam logic       RST_INITOK = 1'b1;
`endif

   lcd_state_e  state_q, state_d;
   logic        init_ok_q, init_ok_d;
   logic [8:0]  pend_q, pend_d;
   logic        pend_valid_q, pend_valid_d;
   logic        done_q, done_d;
   logic [31:0] result_q, result_d;

   logic [8:0]  req;
   logic        req_valid;
   logic        go, go_rs, go_long, fin;
   logic [7:0]  go_byte;
   logic        unused_bits;

   assign unused_bits = ^{dataa[31:9], datab};

   // A start in the same cycle takes priority over an older pending request.
   assign req       = start ? dataa[8:0] : pend_q;
   assign req_valid = start | pend_valid_q;
   assign go_long   = is_long_cmd(go_rs, go_byte);

   always_comb begin
      state_d      = state_q;
      init_ok_d    = init_ok_q;
      pend_d       = pend_q;
      pend_valid_d = pend_valid_q;
      done_d       = done_q;
      result_d     = result_q;
      go           = 1'b0;
      go_byte      = req[7:0];
      go_rs        = req[8];
`ifdef LCD_INIT_SEQ_EN
      cnt_d        = cnt_q;
      rom_idx_d    = rom_idx_q;
`endif
      if (clk_en) begin
         done_d = 1'b0;
         if (start) begin
            pend_d       = dataa[8:0];
            pend_valid_d = 1'b1;
         end
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  go           = 1'b1;
                  pend_valid_d = 1'b0;
                  state_d      = ST_XFER;
               end
            end
            ST_XFER: begin
               if (fin) begin
                  state_d  = ST_DONE;
                  done_d   = 1'b1;
                  result_d = {init_ok_q, 22'b0, lcd_rs, lcd_data};
               end
            end
            ST_DONE: state_d = ST_IDLE;
`ifdef LCD_INIT_SEQ_EN
            ST_PWR_WAIT: begin
               if (cnt_q == PWRUP_LAST) begin
                  cnt_d   = '0;
                  state_d = ST_INIT_LOAD;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            ST_INIT_LOAD: begin
               go      = 1'b1;
               go_byte = init_rom(rom_idx_q);
               go_rs   = 1'b0;
               state_d = ST_INIT_WAIT;
            end
            ST_INIT_WAIT: begin
               if (fin) begin
                  if (rom_idx_q == ROM_LAST) begin
                     init_ok_d = 1'b1;
                     rom_idx_d = '0;
                     if (req_valid) begin
                        go           = 1'b1;
                        pend_valid_d = 1'b0;
                        state_d      = ST_XFER;
                     end else begin
                        state_d = ST_IDLE;
                     end
                  end else begin
                     rom_idx_d = rom_idx_q + 3'd1;
                     state_d   = ST_INIT_LOAD;
                  end
               end
            end
`endif
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= RST_STATE;
         init_ok_q    <= RST_INITOK;
         pend_q       <= '0;
         pend_valid_q <= 1'b0;
         done_q       <= 1'b0;
         result_q     <= '0;
      end else begin
         state_q      <= state_d;
         init_ok_q    <= init_ok_d;
         pend_q       <= pend_d;
         pend_valid_q <= pend_valid_d;
         done_q       <= done_d;
         result_q     <= result_d;
      end
   end

`ifdef LCD_INIT_SEQ_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q     <= '0;
         rom_idx_q <= '0;
      end else begin
         cnt_q     <= cnt_d;
         rom_idx_q <= rom_idx_d;
      end
   end
`endif

   lcd_bus_timer #(
      .SETUP_CYC     (SETUP_CYC),
      .EN_HIGH_CYC   (EN_HIGH_CYC),
      .EXEC_CYC      (EXEC_CYC),
      .LONG_EXEC_CYC (LONG_EXEC_CYC)
   ) u_bus_timer (
      .clk        (clk),
      .reset      (reset),
      .clk_en     (clk_en),
      .go         (go),
      .go_byte    (go_byte),
      .go_rs      (go_rs),
      .go_long    (go_long),
      .fin        (fin),
      .lcd_enable (lcd_enable),
      .lcd_rs     (lcd_rs),
      .lcd_data   (lcd_data)
   );

   assign done   = done_q;
   assign result = result_q;
   assign lcd_rw = 1'b0;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Self-checking bench for lcd_cmd_sequencer: vector table plus hand-written corner sequences,
// with scoreboard queues for expected LCD bus bytes and expected done/result values.
module tb_lcd_cmd_sequencer;

   localparam int BUDGET = 2000;

   logic        clk = 1'b0;
   logic        reset;
   logic        clk_en;
   logic        start;
   logic [31:0] dataa;
   logic [31:0] datab;
   logic [31:0] result;
   logic        done;
   logic        lcd_enable;
   logic        lcd_rs;
   logic        lcd_rw;
   logic [7:0]  lcd_data;

   int tests_run    = 0;
   int tests_failed = 0;
   int en_width_exp = 12;

   logic [8:0]  bus_q[$];
   logic [31:0] res_q[$];

   typedef struct {
      logic [31:0] a;
      int          lat;
      logic [31:0] res;
   } vec_t;
   vec_t vecs[8];

`ifdef LCD_INIT_SEQ_EN
   logic [7:0] rom_bytes[5];
`endif

   lcd_cmd_sequencer #(
      .SETUP_CYC     (2),
      .EN_HIGH_CYC   (12),
      .EXEC_CYC      (20),
      .LONG_EXEC_CYC (50),
      .PWRUP_CYC     (10)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .clk_en     (clk_en),
      .start      (start),
      .dataa      (dataa),
      .datab      (datab),
      .result     (result),
      .done       (done),
      .lcd_enable (lcd_enable),
      .lcd_rs     (lcd_rs),
      .lcd_rw     (lcd_rw),
      .lcd_data   (lcd_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Bus monitor: every enable pulse must carry the next expected byte and have the expected width.
   logic prev_en = 1'b0;
   int   en_width = 0;
   always @(negedge clk) begin
      if (!reset) begin
         prev_en  = 1'b0;
         en_width = 0;
      end else begin
         if (lcd_enable && !prev_en) begin
            en_width = 1;
            if (bus_q.size() == 0) check("pulse_queue_nonempty", bus_q.size(), 1);
            else check("bus_rs_data", {23'b0, lcd_rs, lcd_data}, {23'b0, bus_q.pop_front()});
         end else if (lcd_enable) begin
            en_width++;
         end
         if (!lcd_enable && prev_en) check("en_width", en_width, en_width_exp);
         prev_en = lcd_enable;
      end
   end

   // Done monitor: every done pulse pops one expected result.
   always @(negedge clk) begin
      if (reset && done) begin
         if (res_q.size() == 0) check("done_queue_nonempty", res_q.size(), 1);
         else check("result", result, res_q.pop_front());
         check("lcd_rw", {31'b0, lcd_rw}, 32'h0);
      end
   end

   task automatic run_xfer(input string name, input logic [31:0] a, input logic [31:0] exp_res,
                           input int exp_lat, input int gate_at, input int gate_len);
      int n;
      int rise;
      bit got;
      bus_q.push_back(a[8:0]);
      res_q.push_back(exp_res);
      @(negedge clk);
      start = 1'b1;
      dataa = a;
      datab = $urandom;
      n     = 0;
      rise  = -1;
      got   = 1'b0;
      while (n < BUDGET && !got) begin
         @(negedge clk);
         n++;
         if (n == 1) start = 1'b0;
         if (gate_len > 0 && n == gate_at) clk_en = 1'b0;
         if (gate_len > 0 && n == gate_at + gate_len) clk_en = 1'b1;
         if (lcd_enable && rise < 0) rise = n;
         if (done) got = 1'b1;
      end
      clk_en = 1'b1;
      check({name, "_done_seen"}, {31'b0, got}, 32'h1);
      if (exp_lat >= 0) begin
         check({name, "_done_cycle"}, n, exp_lat);
         check({name, "_en_rise_cycle"}, rise, 3);
      end
      @(negedge clk);
      check({name, "_done_one_cycle"}, {31'b0, done}, 32'h0);
      check({name, "_data_hold"}, {23'b0, lcd_rs, lcd_data}, {23'b0, a[8:0]});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{32'h0000_0141, 35, 32'h8000_0141};
      vecs[1] = '{32'h0000_0001, 65, 32'h8000_0001};
      vecs[2] = '{32'h0000_0002, 65, 32'h8000_0002};
      vecs[3] = '{32'h0000_0003, 65, 32'h8000_0003};
      vecs[4] = '{32'h0000_0004, 35, 32'h8000_0004};
      vecs[5] = '{32'h0000_0101, 35, 32'h8000_0101};
      vecs[6] = '{32'hFFFF_FE38, 35, 32'h8000_0038};
      vecs[7] = '{32'hABCD_E3FF, 35, 32'h8000_01FF};
`ifdef LCD_INIT_SEQ_EN
      rom_bytes = '{8'h38, 8'h38, 8'h0E, 8'h06, 8'h01};
`endif

      reset  = 1'b1;
      clk_en = 1'b1;
      start  = 1'b0;
      dataa  = '0;
      datab  = '0;
      #2 reset = 1'b0;
      #1;
      check("rst_done",       {31'b0, done},       32'h0);
      check("rst_result",     result,              32'h0);
      check("rst_lcd_enable", {31'b0, lcd_enable}, 32'h0);
      check("rst_lcd_rs",     {31'b0, lcd_rs},     32'h0);
      check("rst_lcd_rw",     {31'b0, lcd_rw},     32'h0);
      check("rst_lcd_data",   {24'b0, lcd_data},   32'h0);
      repeat (3) @(negedge clk);
      check("rst_hold_enable", {31'b0, lcd_enable}, 32'h0);
      reset = 1'b1;

`ifdef LCD_INIT_SEQ_EN
      for (int i = 0; i < 5; i++) bus_q.push_back({1'b0, rom_bytes[i]});
      repeat (240) @(negedge clk);
      check("init_all_bytes_issued", bus_q.size(), 0);
      check("init_no_done", res_q.size(), 0);
`endif

      for (int i = 0; i < 8; i++)
         run_xfer($sformatf("vec%0d", i), vecs[i].a, vecs[i].res, vecs[i].lat, 0, 0);

      // clk_en held low for 7 clocks inside the enable pulse stretches pulse and done by 7.
      en_width_exp = 19;
      run_xfer("clk_en_gate", 32'h0000_0141, 32'h8000_0141, 42, 5, 7);
      en_width_exp = 12;

      // Reset during the enable pulse: enable drops at once and the transfer never completes.
      bus_q.push_back(9'h141);
      @(negedge clk);
      start = 1'b1;
      dataa = 32'h0000_0141;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      check("en_before_reset", {31'b0, lcd_enable}, 32'h1);
      #2 reset = 1'b0;
      #1;
      check("reset_en_async_drop", {31'b0, lcd_enable}, 32'h0);
      check("reset_no_done",       {31'b0, done},       32'h0);
      check("reset_data_cleared",  {24'b0, lcd_data},   32'h0);
      repeat (3) @(negedge clk);
      check("reset_result_cleared", result, 32'h0);
      reset = 1'b1;

`ifdef LCD_INIT_SEQ_EN
      // Start during PWR_WAIT: held until the init ROM finishes, then exactly one done.
      for (int i = 0; i < 5; i++) bus_q.push_back({1'b0, rom_bytes[i]});
      run_xfer("start_in_init", 32'h0000_0148, 32'h8000_0148, -1, 0, 0);
`else
      run_xfer("after_reset", 32'h0000_0148, 32'h8000_0148, 35, 0, 0);
`endif

      repeat (100) @(negedge clk);
      check("bus_queue_drained",    bus_q.size(), 0);
      check("result_queue_drained", res_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
